// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the miniRV hazard controller: FSM state encodings,
// operand-forward select codes and the register-hit compare helpers.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    REDIRECT = 2'd3
  } hz_state_e;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  // x0 is hard-wired zero, so it never creates a dependency.
  function automatic logic reg_hit(
    input logic       use_rs,
    input logic [4:0] rs,
    input logic       we,
    input logic [4:0] wr
  );
    return use_rs & we & (wr == rs) & (rs != 5'd0);
  endfunction

  // h = {wb, mem, ex}; the youngest producer holds the live value.
  function automatic logic [1:0] fwd_pick(input logic [2:0] h);
    if (h[0])      return FWD_EX;
    else if (h[1]) return FWD_MEM;
    else if (h[2]) return FWD_WB;
    else           return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_hazard_detect.sv
// Combinational source/destination compare for the ID stage.
// In: ID sources + use flags, EX/MEM/WB dest + write flags.
// Out: hit_ex (any ID source produced by EX), hit_any, youngest fwd selects.
module pipe_hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs1_ID,
  input  logic [4:0] rs2_ID,
  input  logic       rs1_use_ID,
  input  logic       rs2_use_ID,
  input  logic [4:0] wR_EX,
  input  logic [4:0] wR_MEM,
  input  logic [4:0] wR_WB,
  input  logic       rf_we_EX,
  input  logic       rf_we_MEM,
  input  logic       rf_we_WB,
  output logic       hit_ex,
  output logic       hit_any,
  output logic [1:0] fwd_rs1_sel,
  output logic [1:0] fwd_rs2_sel
);

  logic [2:0] h1;
  logic [2:0] h2;

  assign h1[0] = reg_hit(rs1_use_ID, rs1_ID, rf_we_EX,  wR_EX);
  assign h1[1] = reg_hit(rs1_use_ID, rs1_ID, rf_we_MEM, wR_MEM);
  assign h1[2] = reg_hit(rs1_use_ID, rs1_ID, rf_we_WB,  wR_WB);
  assign h2[0] = reg_hit(rs2_use_ID, rs2_ID, rf_we_EX,  wR_EX);
  assign h2[1] = reg_hit(rs2_use_ID, rs2_ID, rf_we_MEM, wR_MEM);
  assign h2[2] = reg_hit(rs2_use_ID, rs2_ID, rf_we_WB,  wR_WB);

  assign hit_ex      = h1[0] | h2[0];
  assign hit_any     = |{h1, h2};
  assign fwd_rs1_sel = fwd_pick(h1);
  assign fwd_rs2_sel = fwd_pick(h2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage miniRV pipeline: stage
// register enables/flushes, operand forward selects, stall/flush counters.
// Ports: cpu_clk, cpu_rst (async, active-high); ID sources/use flags;
// EX/MEM/WB dest + write flags; ld_EX, redirect_EX, dmem_ready, dmem_req_MEM.
// Outputs: *_we, ifid_flush, idex_flush, fwd_rs*_sel, state_o, stall_cnt, flush_cnt.
// Build option PIPE_FWD_EN: forwarding with load-use bubble only; otherwise
// every RAW hit stalls ID until the producer has retired.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             cpu_clk,
  input  logic             cpu_rst,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             rs1_use_ID,
  input  logic             rs2_use_ID,
  input  logic [4:0]       wR_EX,
  input  logic [4:0]       wR_MEM,
  input  logic [4:0]       wR_WB,
  input  logic             rf_we_EX,
  input  logic             rf_we_MEM,
  input  logic             rf_we_WB,
  input  logic             ld_EX,
  input  logic             redirect_EX,
  input  logic             dmem_ready,
  input  logic             dmem_req_MEM,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             idex_we,
  output logic             exmem_we,
  output logic             memwb_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       fwd_rs1_sel,
  output logic [1:0]       fwd_rs2_sel,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hz_state_e  state;
  hz_state_e  nxt;
  logic       hit_ex;
  logic       hit_any;
  logic [1:0] s1;
  logic [1:0] s2;
  logic       mem_wait;

  pipe_hazard_detect u_det (
    .rs1_ID      (rs1_ID),
    .rs2_ID      (rs2_ID),
    .rs1_use_ID  (rs1_use_ID),
    .rs2_use_ID  (rs2_use_ID),
    .wR_EX       (wR_EX),
    .wR_MEM      (wR_MEM),
    .wR_WB       (wR_WB),
    .rf_we_EX    (rf_we_EX),
    .rf_we_MEM   (rf_we_MEM),
    .rf_we_WB    (rf_we_WB),
    .hit_ex      (hit_ex),
    .hit_any     (hit_any),
    .fwd_rs1_sel (s1),
    .fwd_rs2_sel (s2)
  );

  assign mem_wait = dmem_req_MEM & ~dmem_ready;

`ifndef PIPE_FWD_EN
  logic unused_fwd;
  assign unused_fwd = ^{hit_ex, ld_EX, s1, s2};
`endif

  always_comb begin
    nxt         = RUN;
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    idex_we     = 1'b1;
    exmem_we    = 1'b1;
    memwb_we    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
`ifdef PIPE_FWD_EN
    fwd_rs1_sel = s1;
    fwd_rs2_sel = s2;
`else
    fwd_rs1_sel = FWD_RF;
    fwd_rs2_sel = FWD_RF;
`endif
    if (cpu_rst) begin
      {pc_we, ifid_we, idex_we} = 3'b000;
      {exmem_we, memwb_we}      = 2'b00;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      fwd_rs1_sel = FWD_RF;
      fwd_rs2_sel = FWD_RF;
    end else if (mem_wait) begin
      // Whole pipe frozen; a pending redirect stays visible in EX
      // and is taken on the release cycle.
      {pc_we, ifid_we, idex_we} = 3'b000;
      {exmem_we, memwb_we}      = 2'b00;
      nxt = MEM_WAIT;
    end else if (redirect_EX) begin
      // Wrong-path ID instr is discarded, so no data stall applies.
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      nxt        = REDIRECT;
`ifdef PIPE_FWD_EN
    end else if (hit_ex & ld_EX & (state != LU_STALL)) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_flush = 1'b1;
      nxt        = LU_STALL;
`else
    end else if (hit_any) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_flush = 1'b1;
`endif
    end
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state     <= RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= nxt;
      if (!pc_we)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (idex_flush)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized + directed bench for pipe_hazard_ctrl against a
// rule-level reference model.
module tb_pipe_hazard_ctrl;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic [4:0]  rs1_ID, rs2_ID, wR_EX, wR_MEM, wR_WB;
  logic        rs1_use_ID, rs2_use_ID;
  logic        rf_we_EX, rf_we_MEM, rf_we_WB;
  logic        ld_EX, redirect_EX, dmem_ready, dmem_req_MEM;
  logic        pc_we, ifid_we, idex_we, exmem_we, memwb_we;
  logic        ifid_flush, idex_flush;
  logic [1:0]  fwd_rs1_sel, fwd_rs2_sel, state_o;
  logic [31:0] stall_cnt, flush_cnt;

  int n_vec = 0;
  int n_bad = 0;

  int          m_state;
  logic [31:0] m_stall, m_flush;
  int          n_state;
  logic [4:0]  e_we;
  logic        e_iff, e_idf;
  logic [1:0]  e_f1, e_f2;

  always #5 cpu_clk = ~cpu_clk;

  pipe_hazard_ctrl #(.CNT_W(32)) dut (
    .cpu_clk      (cpu_clk),
    .cpu_rst      (cpu_rst),
    .rs1_ID       (rs1_ID),
    .rs2_ID       (rs2_ID),
    .rs1_use_ID   (rs1_use_ID),
    .rs2_use_ID   (rs2_use_ID),
    .wR_EX        (wR_EX),
    .wR_MEM       (wR_MEM),
    .wR_WB        (wR_WB),
    .rf_we_EX     (rf_we_EX),
    .rf_we_MEM    (rf_we_MEM),
    .rf_we_WB     (rf_we_WB),
    .ld_EX        (ld_EX),
    .redirect_EX  (redirect_EX),
    .dmem_ready   (dmem_ready),
    .dmem_req_MEM (dmem_req_MEM),
    .pc_we        (pc_we),
    .ifid_we      (ifid_we),
    .idex_we      (idex_we),
    .exmem_we     (exmem_we),
    .memwb_we     (memwb_we),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .fwd_rs1_sel  (fwd_rs1_sel),
    .fwd_rs2_sel  (fwd_rs2_sel),
    .state_o      (state_o),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    {rs1_ID, rs2_ID, wR_EX, wR_MEM, wR_WB} = '0;
    {rs1_use_ID, rs2_use_ID} = '0;
    {rf_we_EX, rf_we_MEM, rf_we_WB} = '0;
    {ld_EX, redirect_EX, dmem_req_MEM} = '0;
    dmem_ready = 1'b1;
  endtask

  // Reference: evaluate the hazard rules directly from the stage table.
  task automatic model();
    logic [4:0] rs [2];
    logic       us [2];
    logic [4:0] wr [3];
    logic       wv [3];
    logic [1:0] sel [2];
    bit any_h, ex_h, h;
    rs[0] = rs1_ID; rs[1] = rs2_ID;
    us[0] = rs1_use_ID; us[1] = rs2_use_ID;
    wr[0] = wR_EX; wr[1] = wR_MEM; wr[2] = wR_WB;
    wv[0] = rf_we_EX; wv[1] = rf_we_MEM; wv[2] = rf_we_WB;
    any_h = 0; ex_h = 0;
    for (int r = 0; r < 2; r++) begin
      sel[r] = 0;
      for (int s = 2; s >= 0; s--) begin
        h = us[r] && wv[s] && wr[s] == rs[r] && rs[r] != 0;
        if (h) begin
          any_h = 1;
          if (s == 0) ex_h = 1;
          sel[r] = 2'(s + 1);
        end
      end
    end
`ifdef PIPE_FWD_EN
    e_f1 = sel[0]; e_f2 = sel[1];
`else
    e_f1 = 0; e_f2 = 0;
`endif
    e_iff = 0; e_idf = 0; e_we = 5'b11111; n_state = 0;
    if (cpu_rst) begin
      e_we = 0; e_iff = 1; e_idf = 1; e_f1 = 0; e_f2 = 0;
    end else if (dmem_req_MEM && !dmem_ready) begin
      e_we = 0; n_state = 2;
    end else if (redirect_EX) begin
      e_iff = 1; e_idf = 1; n_state = 3;
`ifdef PIPE_FWD_EN
    end else if (ex_h && ld_EX && m_state != 1) begin
      e_we = 5'b00111; e_idf = 1; n_state = 1;
`else
    end else if (any_h) begin
      e_we = 5'b00111; e_idf = 1;
`endif
    end
  endtask

  task automatic cycle();
    #1;
    model();
    chk("we", {pc_we, ifid_we, idex_we, exmem_we, memwb_we}, e_we);
    chk("flush", {ifid_flush, idex_flush}, {e_iff, e_idf});
    chk("fwd1", fwd_rs1_sel, e_f1);
    chk("fwd2", fwd_rs2_sel, e_f2);
    chk("state", state_o, m_state);
    chk("stall_cnt", stall_cnt, m_stall);
    chk("flush_cnt", flush_cnt, m_flush);
    @(posedge cpu_clk);
    m_state = n_state;
    if (!e_we[4]) m_stall++;
    if (e_idf) m_flush++;
    @(negedge cpu_clk);
  endtask

  task automatic do_reset();
    idle();
    cpu_rst = 1'b1;
    #1;
    chk("rst_we", {pc_we, ifid_we, idex_we, exmem_we, memwb_we}, 0);
    chk("rst_flush", {ifid_flush, idex_flush}, 2'b11);
    chk("rst_fwd", {fwd_rs1_sel, fwd_rs2_sel}, 0);
    chk("rst_state", state_o, 0);
    chk("rst_cnt", stall_cnt | flush_cnt, 0);
    @(posedge cpu_clk);
    @(negedge cpu_clk);
    cpu_rst = 1'b0;
    m_state = 0; m_stall = 0; m_flush = 0;
  endtask

  initial begin
    idle();
    cpu_rst = 1'b1;
    @(negedge cpu_clk);
    do_reset();

`ifdef PIPE_FWD_EN
    // add x5 in EX, ID reads x5: forwarded, no stall
    rs1_ID = 5; rs1_use_ID = 1; wR_EX = 5; rf_we_EX = 1;
    #1;
    chk("t1_sel", fwd_rs1_sel, 2'd1);
    chk("t1_pc", pc_we, 1);
    #1 cycle();
    chk("t1_cnt", stall_cnt, 0);

    // lw x6 in EX: one bubble, then forwarded from MEM
    do_reset();
    rs1_ID = 6; rs1_use_ID = 1; wR_EX = 6; rf_we_EX = 1; ld_EX = 1;
    cycle();
    chk("t2_cnt", stall_cnt, 1);
    rf_we_EX = 0; ld_EX = 0; wR_EX = 0; wR_MEM = 6; rf_we_MEM = 1;
    #1;
    chk("t2_sel", fwd_rs1_sel, 2'd2);
    chk("t2_pc", pc_we, 1);
    #1 cycle();
`else
    // add x7 walks EX->MEM->WB while ID is held: three bubbles
    rs1_ID = 7; rs1_use_ID = 1; wR_EX = 7; rf_we_EX = 1;
    cycle();
    rf_we_EX = 0; wR_MEM = 7; rf_we_MEM = 1;
    cycle();
    rf_we_MEM = 0; wR_WB = 7; rf_we_WB = 1;
    cycle();
    rf_we_WB = 0;
    #1;
    chk("t3_cnt", stall_cnt, 3);
    chk("t3_pc", pc_we, 1);
    chk("t3_sel", fwd_rs1_sel, 0);
    #1 cycle();
`endif

    // redirect beats a pending load-use hazard
    do_reset();
    rs1_ID = 6; rs1_use_ID = 1; wR_EX = 6; rf_we_EX = 1; ld_EX = 1;
    redirect_EX = 1;
    #1;
    chk("t4_pc", pc_we, 1);
    chk("t4_fl", {ifid_flush, idex_flush}, 2'b11);
    #1 cycle();
    chk("t4_fcnt", flush_cnt, 1);
    chk("t4_state", state_o, 3);

    // four-cycle data memory wait
    do_reset();
    dmem_req_MEM = 1; dmem_ready = 0;
    repeat (4) cycle();
    chk("t5_cnt", stall_cnt, 4);
    dmem_ready = 1;
    #1;
    chk("t5_rel", {pc_we, ifid_we, idex_we, exmem_we, memwb_we}, 5'h1f);
    #1 cycle();

    // async reset while in MEM_WAIT
    do_reset();
    dmem_req_MEM = 1; dmem_ready = 0;
    cycle();
    cycle();
    #2 cpu_rst = 1'b1;
    #1;
    chk("t6_state", state_o, 0);
    chk("t6_cnt", stall_cnt | flush_cnt, 0);
    @(negedge cpu_clk);
    cpu_rst = 1'b0;
    m_state = 0; m_stall = 0; m_flush = 0;

    // random traffic over a small register pool to force collisions
    for (int i = 0; i < 600; i++) begin
      rs1_ID       = 5'($urandom_range(0, 3));
      rs2_ID       = 5'($urandom_range(0, 3));
      wR_EX        = 5'($urandom_range(0, 3));
      wR_MEM       = 5'($urandom_range(0, 3));
      wR_WB        = 5'($urandom_range(0, 3));
      rs1_use_ID   = 1'($urandom);
      rs2_use_ID   = 1'($urandom);
      rf_we_EX     = 1'($urandom);
      rf_we_MEM    = 1'($urandom);
      rf_we_WB     = 1'($urandom);
      ld_EX        = 1'($urandom);
      redirect_EX  = ($urandom_range(0, 7) == 0);
      dmem_req_MEM = 1'($urandom);
      dmem_ready   = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
